// File: rtl/sdram_arbiter_2p.sv
// Shares one SDRAM controller between two valid/ready requesters; the grant is registered, so m_valid rises 1 cycle after a request.
// Requests wait while a transfer is in flight plus one GAP cycle; ready returns to the granted port as a single-cycle pulse.
module sdram_arbiter_2p #(
  parameter int PRIORITY = 0,
  parameter int AW       = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] s0_addr,
  input  logic [31:0]   s0_din,
  input  logic [3:0]    s0_wmask,
  input  logic          s0_valid,
  output logic [31:0]   s0_dout,
  output logic          s0_ready,
  input  logic [AW-1:0] s1_addr,
  input  logic [31:0]   s1_din,
  input  logic [3:0]    s1_wmask,
  input  logic          s1_valid,
  output logic [31:0]   s1_dout,
  output logic          s1_ready,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_din,
  output logic [3:0]    m_wmask,
  output logic          m_valid,
  input  logic [31:0]   m_dout,
  input  logic          m_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          grant, grant_nxt;
  logic          last_grant, last_grant_nxt;
  logic [AW-1:0] m_addr_nxt;
  logic [31:0]   m_din_nxt;
  logic [3:0]    m_wmask_nxt;
  logic          m_valid_nxt;
  logic          s0_ready_nxt, s1_ready_nxt;
  logic [31:0]   s0_dout_nxt, s1_dout_nxt;
  logic          req0, req1, winner;

  // A port whose ready is currently pulsing has just been served, not re-requested.
  assign req0 = s0_valid & ~s0_ready;
  assign req1 = s1_valid & ~s1_ready;
  assign busy = (state != IDLE);

  always_comb begin
    if (PRIORITY != 0)
      winner = ~req0;
    else if (req0 & req1)
      winner = ~last_grant;
    else
      winner = req1;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    m_addr_nxt     = m_addr;
    m_din_nxt      = m_din;
    m_wmask_nxt    = m_wmask;
    m_valid_nxt    = m_valid;
    s0_ready_nxt   = 1'b0;
    s1_ready_nxt   = 1'b0;
    s0_dout_nxt    = s0_dout;
    s1_dout_nxt    = s1_dout;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          m_addr_nxt     = winner ? s1_addr  : s0_addr;
          m_din_nxt      = winner ? s1_din   : s0_din;
          m_wmask_nxt    = winner ? s1_wmask : s0_wmask;
          m_valid_nxt    = 1'b1;
          grant_nxt      = winner;
          last_grant_nxt = winner;
          state_nxt      = BUSY;
        end
      end
      BUSY: begin
        // Request fields stay frozen here; the controller re-samples them across its own states.
        if (m_ready) begin
          m_valid_nxt = 1'b0;
          if (grant) begin
            s1_ready_nxt = 1'b1;
            s1_dout_nxt  = m_dout;
          end else begin
            s0_ready_nxt = 1'b1;
            s0_dout_nxt  = m_dout;
          end
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      m_addr     <= '0;
      m_din      <= '0;
      m_wmask    <= '0;
      m_valid    <= 1'b0;
      s0_ready   <= 1'b0;
      s1_ready   <= 1'b0;
      s0_dout    <= '0;
      s1_dout    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      m_addr     <= m_addr_nxt;
      m_din      <= m_din_nxt;
      m_wmask    <= m_wmask_nxt;
      m_valid    <= m_valid_nxt;
      s0_ready   <= s0_ready_nxt;
      s1_ready   <= s1_ready_nxt;
      s0_dout    <= s0_dout_nxt;
      s1_dout    <= s1_dout_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter_2p.sv
// Random requesters and a random-latency controller drive one arbiter per PRIORITY mode;
// a transaction-level reference applies the arbitration rules and checks every cycle.
module tb_sdram_arbiter_2p;

  localparam int AW = 25;

  logic clk;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input int inst, input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL p%0d %s: got %0h expected %0h", inst, tag, act, exp);
  endtask

  // Requester policy: hold until served, then re-request (continuous) or maybe drop.
  function automatic logic next_valid(input logic r, input logic v, input logic en, input logic cont);
    if (r) return cont || (en && $urandom_range(0, 1) == 0);
    if (v) return 1'b1;
    return cont || (en && $urandom_range(0, 3) == 0);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_mode
    localparam int PRIO = gi;

    logic          rst;
    logic [AW-1:0] s0_addr, s1_addr, m_addr;
    logic [31:0]   s0_din, s1_din, s0_dout, s1_dout, m_din, m_dout;
    logic [3:0]    s0_wmask, s1_wmask, m_wmask;
    logic          s0_valid, s1_valid, s0_ready, s1_ready, m_valid, m_ready, busy;
    logic          en0, en1, cont0, cont1, stray_req;
    bit            done;

    sdram_arbiter_2p #(.PRIORITY(PRIO), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .s0_addr(s0_addr), .s0_din(s0_din), .s0_wmask(s0_wmask), .s0_valid(s0_valid),
      .s0_dout(s0_dout), .s0_ready(s0_ready),
      .s1_addr(s1_addr), .s1_din(s1_din), .s1_wmask(s1_wmask), .s1_valid(s1_valid),
      .s1_dout(s1_dout), .s1_ready(s1_ready),
      .m_addr(m_addr), .m_din(m_din), .m_wmask(m_wmask), .m_valid(m_valid),
      .m_dout(m_dout), .m_ready(m_ready), .busy(busy)
    );

    initial begin : req0_drv
      logic r, v;
      s0_valid = 1'b0; s0_addr = '0; s0_din = '0; s0_wmask = '0;
      forever begin
        @(negedge clk); r = s0_ready; v = s0_valid;
        @(posedge clk); #1;
        s0_valid = next_valid(r, v, en0, cont0);
        if ($urandom_range(0, 2) == 0) begin
          s0_addr = AW'($urandom); s0_din = $urandom; s0_wmask = 4'($urandom);
        end
      end
    end

    initial begin : req1_drv
      logic r, v;
      s1_valid = 1'b0; s1_addr = '0; s1_din = '0; s1_wmask = '0;
      forever begin
        @(negedge clk); r = s1_ready; v = s1_valid;
        @(posedge clk); #1;
        s1_valid = next_valid(r, v, en1, cont1);
        if ($urandom_range(0, 2) == 0) begin
          s1_addr = AW'($urandom); s1_din = $urandom; s1_wmask = 4'($urandom);
        end
      end
    end

    initial begin : ctrl_model
      int lat;
      lat = -1; m_ready = 1'b0; m_dout = '0;
      forever begin
        @(posedge clk); #1;
        m_ready = 1'b0;
        if (stray_req) m_ready = 1'b1;
        else if (!m_valid) lat = -1;
        else begin
          if (lat == -1) lat = $urandom_range(0, 8);
          if (lat == 0) begin
            m_ready = 1'b1; m_dout = $urandom; lat = -2;
          end else if (lat > 0) lat--;
        end
      end
    end

    // Reference: tracks the open transaction, who owns it, and when the next grant is legal.
    int            cyc = 0, next_ok = 0, resp_cyc = -10;
    bit            p_rst = 1'b1, open = 1'b0, last = 1'b1, g = 1'b0, resp_port = 1'b0, exp_mv, w;
    logic          p_mready = 1'b0;
    logic [31:0]   p_mdout;
    logic          p_req [2];
    logic [AW-1:0] p_addr [2];
    logic [31:0]   p_din [2];
    logic [3:0]    p_wmask [2];
    logic [31:0]   exp_dout [2];
    logic [AW-1:0] h_addr;
    logic [31:0]   h_din;
    logic [3:0]    h_wmask;

    always @(negedge clk) begin
      cyc++;
      if (p_rst) begin
        chk(PRIO, "rst m_valid", 64'(m_valid), 64'(0));
        chk(PRIO, "rst s0_ready", 64'(s0_ready), 64'(0));
        chk(PRIO, "rst s1_ready", 64'(s1_ready), 64'(0));
        chk(PRIO, "rst busy", 64'(busy), 64'(0));
        chk(PRIO, "rst m_addr", 64'(m_addr), 64'(0));
        chk(PRIO, "rst m_din", 64'(m_din), 64'(0));
        chk(PRIO, "rst m_wmask", 64'(m_wmask), 64'(0));
        chk(PRIO, "rst s0_dout", 64'(s0_dout), 64'(0));
        chk(PRIO, "rst s1_dout", 64'(s1_dout), 64'(0));
        open = 1'b0; last = 1'b1; next_ok = cyc; resp_cyc = -10;
        exp_dout[0] = '0; exp_dout[1] = '0;
      end else begin
        exp_mv = 1'b0;
        if (open && p_mready) begin
          open = 1'b0; resp_cyc = cyc; resp_port = g;
          exp_dout[g] = p_mdout;
          next_ok = cyc + 1;
        end else if (open) begin
          exp_mv = 1'b1;
        end else if (cyc - 1 >= next_ok && (p_req[0] || p_req[1])) begin
          if (PRIO != 0) w = p_req[0] ? 1'b0 : 1'b1;
          else if (p_req[0] && p_req[1]) w = !last;
          else w = p_req[1];
          g = w; last = w; open = 1'b1; exp_mv = 1'b1;
          h_addr = p_addr[w]; h_din = p_din[w]; h_wmask = p_wmask[w];
        end
        chk(PRIO, "m_valid", 64'(m_valid), 64'(exp_mv));
        if (open) begin
          chk(PRIO, "m_addr", 64'(m_addr), 64'(h_addr));
          chk(PRIO, "m_din", 64'(m_din), 64'(h_din));
          chk(PRIO, "m_wmask", 64'(m_wmask), 64'(h_wmask));
        end
        chk(PRIO, "s0_ready", 64'(s0_ready), 64'(resp_cyc == cyc && resp_port == 1'b0));
        chk(PRIO, "s1_ready", 64'(s1_ready), 64'(resp_cyc == cyc && resp_port == 1'b1));
        chk(PRIO, "s0_dout", 64'(s0_dout), 64'(exp_dout[0]));
        chk(PRIO, "s1_dout", 64'(s1_dout), 64'(exp_dout[1]));
        chk(PRIO, "busy", 64'(busy), 64'(open || resp_cyc == cyc));
      end
      p_rst = rst; p_mready = m_ready; p_mdout = m_dout;
      p_req[0] = s0_valid && !s0_ready; p_req[1] = s1_valid && !s1_ready;
      p_addr[0] = s0_addr; p_din[0] = s0_din; p_wmask[0] = s0_wmask;
      p_addr[1] = s1_addr; p_din[1] = s1_din; p_wmask[1] = s1_wmask;
    end

    initial begin : seq
      bit found;
      int idle_n;
      rst = 1'b1; en0 = 1'b0; en1 = 1'b0; cont0 = 1'b0; cont1 = 1'b0;
      stray_req = 1'b0; done = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      // Single-port phases first, then random mixes of enabled ports.
      for (int s = 0; s < 8; s++) begin
        if (s < 2) begin
          en0 = (s == 0); en1 = (s == 1);
        end else begin
          en0 = 1'($urandom_range(0, 1)); en1 = 1'($urandom_range(0, 1));
        end
        repeat (100) @(posedge clk);
        #1;
      end
      en0 = 1'b1; en1 = 1'b1;
      for (int r = 0; r < 3; r++) begin
        repeat ($urandom_range(5, 40)) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
          @(negedge clk);
          if (m_valid && !m_ready) found = 1'b1;
        end
        chk(PRIO, "busy_wait", 64'(found), 64'(1));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
      cont0 = 1'b1; cont1 = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      cont0 = 1'b0; cont1 = 1'b0; en0 = 1'b0; en1 = 1'b0;
      idle_n = 0;
      for (int i = 0; i < 500 && idle_n < 4; i++) begin
        @(negedge clk);
        idle_n = (!busy && !s0_valid && !s1_valid && !m_valid) ? idle_n + 1 : 0;
      end
      chk(PRIO, "quiesce", 64'(idle_n >= 4), 64'(1));
      repeat (4) begin
        @(negedge clk); stray_req = 1'b1;
        @(negedge clk); stray_req = 1'b0;
        repeat (3) @(negedge clk);
      end
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(g_mode[0].done && g_mode[1].done); i++) @(posedge clk);
    if (!(g_mode[0].done && g_mode[1].done)) chk(9, "timeout", 64'(0), 64'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
